// File: rtl/asic_pkg.sv
// Shared types and constants for the ASIC register-page unlock detector
// and other CRTC port watchers.
package asic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    MATCH  = 2'd2,
    DECIDE = 2'd3
  } unlock_state_t;

  // CPC Plus unlock table as seen after the non-zero/zero sync pair, byte 0 in the MSBs.
  localparam int          PLUS_TABLE_LEN = 13;
  localparam logic [103:0] PLUS_TABLE    = {8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62,
                                           8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A};

  localparam logic [7:0] ASIC_UNLOCK_BYTE = 8'hCD;
  localparam logic [7:0] CRTC_PORT_HI     = 8'hBC;

endpackage

// File: rtl/io_wr_edge.sv
// Qualifies a CPU I/O write strobe: one accept per rising strobe edge when the
// upper address byte matches PORT_HI and the watcher is enabled.
module io_wr_edge #(
  parameter logic [7:0] PORT_HI = 8'hBC
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] addr_hi,
  input  logic [7:0] data_in,
  input  logic       io_wr,
  output logic       accept,
  output logic [7:0] data_q
);

  logic wr_q;

  // Tracks the strobe even while disabled, so a strobe already high on enable is ignored.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) wr_q <= 1'b0;
    else          wr_q <= io_wr;
  end

  assign accept = io_wr && !wr_q && (addr_hi == PORT_HI) && enable;
  assign data_q = accept ? data_in : 8'h00;

endmodule

// File: rtl/asic_unlock_seq.sv
// ASIC register-page lock/unlock sequence detector on the CRTC select port.
// Optional statistics outputs are built when ASIC_UNLOCK_STATS_EN is defined.
module asic_unlock_seq
  import asic_pkg::*;
#(
  parameter int                     MATCH_LEN   = 14,
  // Default table is the Plus table followed by one zero pad byte.
  parameter logic [MATCH_LEN*8-1:0] MATCH_SEQ   = {PLUS_TABLE, 8'h00},
  parameter logic [7:0]             UNLOCK_BYTE = ASIC_UNLOCK_BYTE,
  parameter logic [7:0]             PORT_HI     = CRTC_PORT_HI,
  parameter bit                     STICKY      = 1'b0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        plus_mode,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_io_wr,
  output logic        unlocked,
  output logic        unlock_pulse,
  output logic        lock_pulse,
  output logic        seq_busy,
  output logic [4:0]  seq_index
`ifdef ASIC_UNLOCK_STATS_EN
  ,
  output logic [15:0] attempt_cnt,
  output logic [4:0]  last_fail_idx
`endif
);

  if (MATCH_LEN < 1 || MATCH_LEN > 31) begin : g_bad_len
    $error("asic_unlock_seq: MATCH_LEN must be within 1..31");
  end

  localparam logic [4:0] LAST_IDX = 5'(MATCH_LEN - 1);

  unlock_state_t state_q;
  logic [4:0]    idx_q;
  logic          unlocked_q, unlock_pulse_q, lock_pulse_q;
  logic          accept;
  logic [7:0]    data;
  logic [7:0]    tbl [32];
  logic          unused_addr_lo;

  assign unused_addr_lo = ^cpu_addr[7:0];

  io_wr_edge #(.PORT_HI(PORT_HI)) u_wr_edge (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .enable  (plus_mode),
    .addr_hi (cpu_addr[15:8]),
    .data_in (cpu_data_in),
    .io_wr   (cpu_io_wr),
    .accept  (accept),
    .data_q  (data)
  );

  // Unpack the table into a 32-entry lookup so the 5-bit index never runs off the end.
  for (genvar gi = 0; gi < 32; gi++) begin : g_tbl
    if (gi < MATCH_LEN) begin : g_used
      assign tbl[gi] = MATCH_SEQ[(MATCH_LEN-1-gi)*8 +: 8];
    end else begin : g_pad
      assign tbl[gi] = 8'h00;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      idx_q          <= 5'd0;
      unlocked_q     <= 1'b0;
      unlock_pulse_q <= 1'b0;
      lock_pulse_q   <= 1'b0;
    end else begin
      unlock_pulse_q <= 1'b0;
      lock_pulse_q   <= 1'b0;
      if (!plus_mode) begin
        state_q    <= IDLE;
        idx_q      <= 5'd0;
        unlocked_q <= 1'b0;
      end else if (accept) begin
        case (state_q)
          IDLE: if (data != 8'h00) state_q <= SYNC;
          SYNC: if (data == 8'h00) begin
            state_q <= MATCH;
            idx_q   <= 5'd0;
          end
          MATCH: begin
            if (data == tbl[idx_q]) begin
              if (idx_q == LAST_IDX) begin
                state_q <= DECIDE;
                idx_q   <= 5'd0;
              end else begin
                idx_q <= idx_q + 5'd1;
              end
            end else begin
              state_q <= (data == 8'h00) ? MATCH : SYNC;
              idx_q   <= 5'd0;
            end
          end
          DECIDE: begin
            if (data == UNLOCK_BYTE) begin
              unlocked_q     <= 1'b1;
              unlock_pulse_q <= !unlocked_q;
            end else if (!STICKY) begin
              unlocked_q   <= 1'b0;
              lock_pulse_q <= unlocked_q;
            end
            state_q <= (data != 8'h00) ? SYNC : IDLE;
            idx_q   <= 5'd0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign unlocked     = unlocked_q;
  assign unlock_pulse = unlock_pulse_q;
  assign lock_pulse   = lock_pulse_q;
  assign seq_busy     = (state_q != IDLE);
  assign seq_index    = idx_q;

`ifdef ASIC_UNLOCK_STATS_EN
  logic [15:0] attempt_cnt_q, attempt_cnt_d;
  logic [4:0]  last_fail_idx_q, last_fail_idx_d;
  logic        sync_to_match, match_fail;

  assign sync_to_match = accept && (state_q == SYNC) && (data == 8'h00);
  assign match_fail    = accept && (state_q == MATCH) && (data != tbl[idx_q]);

  always_comb begin
    attempt_cnt_d   = attempt_cnt_q;
    last_fail_idx_d = last_fail_idx_q;
    if (sync_to_match && attempt_cnt_q != 16'hFFFF) attempt_cnt_d = attempt_cnt_q + 16'd1;
    if (match_fail) last_fail_idx_d = idx_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      attempt_cnt_q   <= 16'd0;
      last_fail_idx_q <= 5'd0;
    end else begin
      attempt_cnt_q   <= attempt_cnt_d;
      last_fail_idx_q <= last_fail_idx_d;
    end
  end

  assign attempt_cnt   = attempt_cnt_q;
  assign last_fail_idx = last_fail_idx_q;
`endif

endmodule

// File: tb/tb_asic_unlock_seq.sv
// Directed bench for asic_unlock_seq: a normal and a STICKY instance share stimulus.
// Statistics checks are compiled in when ASIC_UNLOCK_STATS_EN is defined.
module tb_asic_unlock_seq;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        plus_mode;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_io_wr;
  logic        unlocked, unlock_pulse, lock_pulse, seq_busy;
  logic [4:0]  seq_index;
  logic        unlocked_s, unlock_pulse_s, lock_pulse_s, seq_busy_s;
  logic [4:0]  seq_index_s;
`ifdef ASIC_UNLOCK_STATS_EN
  logic [15:0] attempt_cnt, attempt_cnt_s;
  logic [4:0]  last_fail_idx, last_fail_idx_s;
`endif

  always #5 clk_sys = ~clk_sys;

  asic_unlock_seq #(
    .MATCH_LEN(13), .MATCH_SEQ(104'hFF77B351A8D462399C462B158A),
    .UNLOCK_BYTE(8'hCD), .PORT_HI(8'hBC), .STICKY(1'b0)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .plus_mode(plus_mode),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_io_wr(cpu_io_wr),
    .unlocked(unlocked), .unlock_pulse(unlock_pulse), .lock_pulse(lock_pulse),
    .seq_busy(seq_busy), .seq_index(seq_index)
`ifdef ASIC_UNLOCK_STATS_EN
    , .attempt_cnt(attempt_cnt), .last_fail_idx(last_fail_idx)
`endif
  );

  asic_unlock_seq #(
    .MATCH_LEN(13), .MATCH_SEQ(104'hFF77B351A8D462399C462B158A),
    .UNLOCK_BYTE(8'hCD), .PORT_HI(8'hBC), .STICKY(1'b1)
  ) dut_s (
    .clk_sys(clk_sys), .reset_n(reset_n), .plus_mode(plus_mode),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_io_wr(cpu_io_wr),
    .unlocked(unlocked_s), .unlock_pulse(unlock_pulse_s), .lock_pulse(lock_pulse_s),
    .seq_busy(seq_busy_s), .seq_index(seq_index_s)
`ifdef ASIC_UNLOCK_STATS_EN
    , .attempt_cnt(attempt_cnt_s), .last_fail_idx(last_fail_idx_s)
`endif
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        busy;
    logic [4:0]  idx;
    logic        unl, up, lp;
    logic        unl_s, up_s;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] seq_bytes [13] = '{8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62,
                                 8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A};
  int n_checks = 0;
  int n_fail   = 0;
  int up_cnt = 0, lp_cnt = 0, up_cnt_s = 0, lp_cnt_s = 0;

  always @(negedge clk_sys) begin
    if (unlock_pulse === 1'b1)   up_cnt++;
    if (lock_pulse === 1'b1)     lp_cnt++;
    if (unlock_pulse_s === 1'b1) up_cnt_s++;
    if (lock_pulse_s === 1'b1)   lp_cnt_s++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] a, input logic [7:0] d, input logic b, input int ix,
                     input logic u, input logic up, input logic lp, input logic us, input logic ups);
    vec_t v;
    v.addr = a; v.data = d; v.busy = b; v.idx = 5'(ix);
    v.unl = u; v.up = up; v.lp = lp; v.unl_s = us; v.up_s = ups;
    vecs.push_back(v);
  endtask

  // Single-clock strobe: called on a negedge, returns on the negedge after the accepting edge.
  task automatic wr_byte(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_data_in = d; cpu_io_wr = 1'b1;
    @(negedge clk_sys);
    cpu_io_wr = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      wr_byte(vecs[i].addr, vecs[i].data);
      $display("vec %0d: wr %h<=%h unl=%b busy=%b idx=%0d up=%b lp=%b | sticky unl=%b",
               i, vecs[i].addr, vecs[i].data, unlocked, seq_busy, seq_index,
               unlock_pulse, lock_pulse, unlocked_s);
      chk($sformatf("v%0d busy", i), 32'(seq_busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d idx", i), 32'(seq_index), 32'(vecs[i].idx));
      chk($sformatf("v%0d unlocked", i), 32'(unlocked), 32'(vecs[i].unl));
      chk($sformatf("v%0d unlock_pulse", i), 32'(unlock_pulse), 32'(vecs[i].up));
      chk($sformatf("v%0d lock_pulse", i), 32'(lock_pulse), 32'(vecs[i].lp));
      chk($sformatf("v%0d sticky unlocked", i), 32'(unlocked_s), 32'(vecs[i].unl_s));
      chk($sformatf("v%0d sticky unlock_pulse", i), 32'(unlock_pulse_s), 32'(vecs[i].up_s));
      chk($sformatf("v%0d sticky lock_pulse", i), 32'(lock_pulse_s), 32'd0);
      @(negedge clk_sys);
    end
  endtask

  task automatic hold_wr(input logic [7:0] d, input int cycles);
    cpu_addr = 16'hBC00; cpu_data_in = d; cpu_io_wr = 1'b1;
    repeat (cycles) @(negedge clk_sys);
    cpu_io_wr = 1'b0;
    @(negedge clk_sys);
  endtask

  int a_lo, a_hi, b_lo, b_hi, c_lo, c_hi, d_lo, d_hi;

  initial begin
    // Phase A: full unlock from IDLE, trailing &EE leaves SYNC.
    a_lo = vecs.size();
    add(16'hBC00, 8'hFF, 1, 0, 0, 0, 0, 0, 0);
    add(16'hBC00, 8'h00, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) add(16'hBC00, seq_bytes[i], 1, (i == 12) ? 0 : i + 1, 0, 0, 0, 0, 0);
    add(16'hBC00, 8'hCD, 1, 0, 1, 1, 0, 1, 1);
    add(16'hBC00, 8'hEE, 1, 0, 1, 0, 0, 1, 0);
    a_hi = vecs.size() - 1;
    // Phase B: same sequence with &A5 as the decision byte.
    b_lo = vecs.size();
    add(16'hBC00, 8'hFF, 1, 0, 1, 0, 0, 1, 0);
    add(16'hBC00, 8'h00, 1, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 13; i++) add(16'hBC00, seq_bytes[i], 1, (i == 12) ? 0 : i + 1, 1, 0, 0, 1, 0);
    add(16'hBC00, 8'hA5, 1, 0, 0, 0, 1, 1, 0);
    add(16'hBC00, 8'hEE, 1, 0, 0, 0, 0, 1, 0);
    b_hi = vecs.size() - 1;
    // Phase C: mismatches at index 5, then a full correct sequence.
    c_lo = vecs.size();
    add(16'hBC00, 8'h00, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) add(16'hBC00, seq_bytes[i], 1, i + 1, 0, 0, 0, 1, 0);
    add(16'hBC00, 8'h00, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) add(16'hBC00, seq_bytes[i], 1, i + 1, 0, 0, 0, 1, 0);
    add(16'hBC00, 8'h12, 1, 0, 0, 0, 0, 1, 0);
    add(16'hBC00, 8'hFF, 1, 0, 0, 0, 0, 1, 0);
    add(16'hBC00, 8'h00, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 13; i++) add(16'hBC00, seq_bytes[i], 1, (i == 12) ? 0 : i + 1, 0, 0, 0, 1, 0);
    add(16'hBC00, 8'hCD, 1, 0, 1, 1, 0, 1, 0);
    add(16'hBC00, 8'hEE, 1, 0, 1, 0, 0, 1, 0);
    c_hi = vecs.size() - 1;
    // Phase D: traffic to &BD00 is ignored.
    d_lo = vecs.size();
    add(16'hBD00, 8'hFF, 0, 0, 0, 0, 0, 0, 0);
    add(16'hBD00, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    add(16'hBD00, 8'hFF, 0, 0, 0, 0, 0, 0, 0);
    d_hi = vecs.size() - 1;

    reset_n = 1'b0; plus_mode = 1'b1; cpu_addr = 16'h0000; cpu_data_in = 8'h00; cpu_io_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("reset unlocked", 32'(unlocked), 32'd0);
    chk("reset unlock_pulse", 32'(unlock_pulse), 32'd0);
    chk("reset lock_pulse", 32'(lock_pulse), 32'd0);
    chk("reset seq_busy", 32'(seq_busy), 32'd0);
    chk("reset seq_index", 32'(seq_index), 32'd0);

    run_vecs(a_lo, a_hi);
    run_vecs(b_lo, b_hi);
    run_vecs(c_lo, c_hi);

    // Async reset in the middle of the table, at index 8.
    wr_byte(16'hBC00, 8'h00); @(negedge clk_sys);
    for (int i = 0; i < 8; i++) begin wr_byte(16'hBC00, seq_bytes[i]); @(negedge clk_sys); end
    chk("midreset idx before", 32'(seq_index), 32'd8);
    #2 reset_n = 1'b0;
    #1;
    $display("async reset at idx 8: unl=%b busy=%b idx=%0d lp=%b", unlocked, seq_busy, seq_index, lock_pulse);
    chk("midreset unlocked", 32'(unlocked), 32'd0);
    chk("midreset sticky unlocked", 32'(unlocked_s), 32'd0);
    chk("midreset idx", 32'(seq_index), 32'd0);
    chk("midreset busy", 32'(seq_busy), 32'd0);
    chk("midreset lock_pulse", 32'(lock_pulse), 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);

    run_vecs(a_lo, a_hi);

    // plus_mode dropped while unlocked.
    plus_mode = 1'b0;
    @(negedge clk_sys);
    $display("plus_mode low: unl=%b busy=%b idx=%0d lp=%b", unlocked, seq_busy, seq_index, lock_pulse);
    chk("plusoff unlocked", 32'(unlocked), 32'd0);
    chk("plusoff sticky unlocked", 32'(unlocked_s), 32'd0);
    chk("plusoff lock_pulse", 32'(lock_pulse), 32'd0);
    chk("plusoff busy", 32'(seq_busy), 32'd0);
    chk("plusoff idx", 32'(seq_index), 32'd0);

    // Strobe already high when plus_mode rises must not be accepted.
    cpu_addr = 16'hBC00; cpu_data_in = 8'hFF; cpu_io_wr = 1'b1;
    @(negedge clk_sys);
    plus_mode = 1'b1;
    repeat (3) @(negedge clk_sys);
    cpu_io_wr = 1'b0;
    @(negedge clk_sys);
    $display("strobe before plus_mode: busy=%b", seq_busy);
    chk("plus rise busy", 32'(seq_busy), 32'd0);

    run_vecs(d_lo, d_hi);

    // Long strobes: one accept each, so FF,00,FF lands on MATCH index 1.
    hold_wr(8'hFF, 10);
    $display("held FF: busy=%b idx=%0d", seq_busy, seq_index);
    chk("held FF busy", 32'(seq_busy), 32'd1);
    hold_wr(8'h00, 10);
    hold_wr(8'hFF, 10);
    $display("held FF,00,FF: busy=%b idx=%0d", seq_busy, seq_index);
    chk("held seq idx", 32'(seq_index), 32'd1);
    chk("held seq busy", 32'(seq_busy), 32'd1);

    // Three sync attempts, the last mismatch at index 3.
    reset_n = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
`ifdef ASIC_UNLOCK_STATS_EN
    chk("stats reset attempt_cnt", 32'(attempt_cnt), 32'd0);
    chk("stats reset last_fail_idx", 32'(last_fail_idx), 32'd0);
`endif
    begin
      logic [7:0] att [12] = '{8'hFF, 8'h00, 8'hFF, 8'h22, 8'h00, 8'hFF,
                               8'h77, 8'hB3, 8'h11, 8'h00, 8'hFF, 8'h77};
      for (int i = 0; i < 12; i++) begin wr_byte(16'hBC00, att[i]); @(negedge clk_sys); end
    end
    $display("attempts: busy=%b idx=%0d", seq_busy, seq_index);
    chk("attempts idx", 32'(seq_index), 32'd2);
`ifdef ASIC_UNLOCK_STATS_EN
    $display("stats: attempt_cnt=%0d last_fail_idx=%0d", attempt_cnt, last_fail_idx);
    chk("stats attempt_cnt", 32'(attempt_cnt), 32'd3);
    chk("stats last_fail_idx", 32'(last_fail_idx), 32'd3);
`endif

    chk("total unlock pulses", 32'(up_cnt), 32'd3);
    chk("total lock pulses", 32'(lp_cnt), 32'd1);
    chk("total sticky unlock pulses", 32'(up_cnt_s), 32'd2);
    chk("total sticky lock pulses", 32'(lp_cnt_s), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/asic_unlock_seq.md
Name: asic_unlock_seq

Overview:
- Parametrised successor to the Plus ASIC lock/unlock detector.
- Watches CPU I/O writes to the CRTC select port (&BCxx) and runs a sync phase followed by a configurable match table.
- A final decision byte either unlocks or re-locks the ASIC register page.
- Sits beside the CRTC port decode and drives the page-enable (`unlocked`) into the ASIC RAM/register mapper.

Parameters:
- MATCH_LEN, 14, number of table bytes after sync (range 1..31).
- MATCH_SEQ, {8'hFF,8'h77,8'hB3,8'h51,8'hA8,8'hD4,8'h62,8'h39,8'h9C,8'h46,8'h2B,8'h15,8'h8A} padded to MATCH_LEN*8 bits, table; byte 0 in the MSBs.
- UNLOCK_BYTE, 8'hCD, decision value that unlocks.
- PORT_HI, 8'hBC, cpu_addr[15:8] match value.
- STICKY, 0, 1 means a wrong decision byte does not re-lock.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- plus_mode  in  1  Plus features enabled
- cpu_addr  in  16  CPU address
- cpu_data_in  in  8  CPU write data
- cpu_io_wr  in  1  I/O write strobe, level, may span many clocks
- unlocked  out  1  ASIC page enabled
- unlock_pulse  out  1  one-clock pulse on unlock
- lock_pulse  out  1  one-clock pulse on re-lock
- seq_busy  out  1  state is SYNC, MATCH or DECIDE
- seq_index  out  5  current table index (0 outside MATCH)

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, idx=0, wr_q=0.
  - All outputs 0.
- Accepted write:
  - Condition: cpu_io_wr=1 and wr_q=0 and cpu_addr[15:8]==PORT_HI and plus_mode=1.
  - cpu_data_in is sampled on that same clock.
  - wr_q is the previous-cycle cpu_io_wr.
  - Exactly one accept per strobe regardless of strobe length.
- State machine, evaluated only on an accepted write:
  - IDLE: d!=0 -> SYNC; d==0 -> stay.
  - SYNC: d==0 -> MATCH with idx=0; d!=0 -> stay.
  - MATCH, d==MATCH_SEQ[idx]:
    - If idx==MATCH_LEN-1 -> DECIDE.
    - Otherwise idx+1.
  - MATCH, mismatch: d==0 -> MATCH with idx=0 (resync); d!=0 -> SYNC with idx=0.
  - DECIDE, d==UNLOCK_BYTE:
    - unlocked<=1.
    - unlock_pulse=1 only if unlocked was 0.
  - DECIDE, other d:
    - If STICKY==0: unlocked<=0, and lock_pulse=1 only if unlocked was 1.
    - If STICKY==1: no change.
  - DECIDE exit: next state SYNC if d!=0, IDLE if d==0. idx=0.
- Trailing bytes (e.g. &EE) are ordinary input; they resync the machine without effect.
- Latency: outputs are registered and change on the clock edge after the accepted write cycle.
- Pulses: width exactly 1 clk_sys cycle, default 0.
- Writes to other ports, reads, and held strobes: no effect on state.
- unlocked is retained through non-matching traffic; only DECIDE or the conditions below change it.
- plus_mode=0:
  - Synchronous clear of state, idx and unlocked.
  - No pulses, including when unlocked drops.
  - wr_q still tracks cpu_io_wr, so a strobe already high when plus_mode rises is not accepted.
- Reset mid-sequence: immediate return to IDLE and locked.
- idx is 5 bits and never exceeds MATCH_LEN-1. Elaboration error if MATCH_LEN is 0 or greater than 31.

Optional Feature:
- ASIC_UNLOCK_STATS_EN defined:
  - Adds outputs attempt_cnt[15:0]: increments on each SYNC->MATCH transition, saturates at 16'hFFFF.
  - Adds last_fail_idx[4:0]: idx at the most recent MATCH mismatch.
  - Both reset to 0.
- Undefined: these ports and their registers are absent. Functional behaviour is identical.

Decomposition:
- Package asic_pkg:
  - Enum unlock_state_t {IDLE, SYNC, MATCH, DECIDE}, 2 bits.
  - Default CPC Plus table constant.
  - Constants ASIC_UNLOCK_BYTE=8'hCD and CRTC_PORT_HI=8'hBC.
- Sub-module io_wr_edge: strobe edge plus port-match qualifier, outputs accept and data_q. Reused by other port watchers.

Test Plan:
- Full sequence &FF,&00,&FF,&77,&B3,&51,&A8,&D4,&62,&39,&9C,&46,&2B,&15,&8A,&CD,&EE to &BC00 -> unlock_pulse once after the &CD write, unlocked=1, state SYNC after &EE.
- Unlocked, then the same sequence with &A5 in place of &CD -> lock_pulse once, unlocked=0. Repeat with STICKY=1 -> unlocked stays 1, no pulse.
- Mismatch &00 injected at table index 5 -> MATCH idx=0. Mismatch &12 at index 5 -> SYNC. A full correct sequence afterwards still unlocks.
- Single write strobe held 10 clocks, and the sequence sent to &BD00 -> at most one accept per strobe. &BD00 traffic gives no state change and seq_busy stays 0.
- reset_n pulsed low at index 8, or plus_mode dropped while unlocked -> unlocked=0 immediately, no lock_pulse, seq_index=0.
- With ASIC_UNLOCK_STATS_EN: three sync attempts, one failing at index 3 -> attempt_cnt=3, last_fail_idx=3.
